// File: rtl/xaui_link_sequencer.sv
// xaui_link_sequencer: per-port XAUI MGT bring-up and recovery.
// Sequences lane resets, alignment and bonding; tracks link health.
module xaui_link_sequencer #(
  parameter int unsigned RESET_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned ALIGN_TIMEOUT = 50000,
  parameter int unsigned STABLE_CYCLES = 256
) (
  input  logic        mgt_clk,
  input  logic        reset_n,
  input  logic        force_reset,
  input  logic        powerdown_req,
  input  logic [3:0]  mgt_rxlock,
  input  logic [3:0]  mgt_syncok,
  input  logic [7:0]  mgt_codevalid,
  input  logic [3:0]  mgt_rxbufferr,
  output logic [3:0]  mgt_tx_reset,
  output logic [3:0]  mgt_rx_reset,
  output logic [3:0]  mgt_enable_align,
  output logic        mgt_enchansync,
  output logic        mgt_powerdown,
  output logic        link_up,
  output logic [2:0]  seq_state,
  output logic [7:0]  retry_count,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    RESET_ALL = 3'd0,
    WAIT_LOCK = 3'd1,
    ALIGN     = 3'd2,
    UP        = 3'd3,
    RX_RESET  = 3'd4,
    POWERDOWN = 3'd5
  } state_t;

  localparam logic [19:0] RST_LAST   = 20'(RESET_CYCLES - 1);
  localparam logic [19:0] LOCK_LAST  = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] ALIGN_LAST = 20'(ALIGN_TIMEOUT - 1);
  localparam logic [15:0] STB_LAST   = 16'(STABLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [19:0] timer, timer_nxt;
  logic [15:0] good_cnt, good_nxt;
  logic        retry_inc, err_inc;

  logic lock_ok, rx_ok, buf_err, good;
  logic up_lost, up_buf, up_drift;

  assign lock_ok = &mgt_rxlock;
  assign rx_ok   = (&mgt_syncok) & (&mgt_codevalid);
  assign buf_err = |mgt_rxbufferr;
  assign good    = lock_ok & rx_ok & ~buf_err;

  // UP exit causes, made exclusive so lock loss dominates
  assign up_lost  = ~lock_ok;
  assign up_buf   = lock_ok & buf_err;
  assign up_drift = lock_ok & ~buf_err & ~rx_ok;

  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    unique case (state)
      RESET_ALL: begin
        if (timer == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_nxt = ALIGN;
        end else if (timer == LOCK_LAST) begin
          state_nxt = RESET_ALL;
          retry_inc = 1'b1;
        end
      end
      ALIGN: begin
        if (good && good_cnt == STB_LAST) begin
          state_nxt = UP;
        end else if (timer == ALIGN_LAST) begin
          state_nxt = RESET_ALL;
          retry_inc = 1'b1;
        end
      end
      UP: begin
        unique case (1'b1)
          up_lost:  state_nxt = RESET_ALL;
          up_buf:   state_nxt = RX_RESET;
          up_drift: state_nxt = ALIGN;
          default:  state_nxt = UP;
        endcase
      end
      RX_RESET: begin
        if (timer == RST_LAST) state_nxt = WAIT_LOCK;
      end
      POWERDOWN: state_nxt = RESET_ALL;
      default:   state_nxt = RESET_ALL;
    endcase

    if (powerdown_req) begin
      state_nxt = POWERDOWN;
      retry_inc = 1'b0;
    end else if (force_reset) begin
      state_nxt = RESET_ALL;
      retry_inc = 1'b0;
    end
  end

  assign err_inc = (state == UP) && (state_nxt != UP);

  always_comb begin
    timer_nxt = timer;
    if (state_nxt != state || (force_reset && !powerdown_req))
      timer_nxt = '0;
    else if (timer != '1)
      timer_nxt = timer + 20'd1;
  end

  always_comb begin
    good_nxt = '0;
    if (state == ALIGN && state_nxt == ALIGN && good)
      good_nxt = good_cnt + 16'd1;
  end

  always_ff @(posedge mgt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESET_ALL;
      timer       <= '0;
      good_cnt    <= '0;
      retry_count <= '0;
      err_count   <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      good_cnt <= good_nxt;
      if (retry_inc && retry_count != 8'hFF)
        retry_count <= retry_count + 8'd1;
      if (err_inc && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

  always_comb begin
    mgt_tx_reset     = 4'h0;
    mgt_rx_reset     = 4'h0;
    mgt_enable_align = 4'h0;
    mgt_enchansync   = 1'b0;
    mgt_powerdown    = 1'b0;
    link_up          = 1'b0;
    unique case (state)
      RESET_ALL: begin
        mgt_tx_reset = 4'hF;
        mgt_rx_reset = 4'hF;
      end
      WAIT_LOCK: ;
      ALIGN: begin
        mgt_enable_align = 4'hF;
        mgt_enchansync   = 1'b1;
      end
      UP: begin
        mgt_enchansync = 1'b1;
        link_up        = 1'b1;
      end
      RX_RESET: mgt_rx_reset = 4'hF;
      POWERDOWN: begin
        mgt_powerdown = 1'b1;
        mgt_tx_reset  = 4'hF;
        mgt_rx_reset  = 4'hF;
      end
      default: begin
        mgt_tx_reset = 4'hF;
        mgt_rx_reset = 4'hF;
      end
    endcase
  end

  assign seq_state = state;

endmodule

// File: tb/tb_xaui_link_sequencer.sv
// tb_xaui_link_sequencer: directed checks of bring-up, retry,
// recovery, powerdown and async reset with small timing parameters.
module tb_xaui_link_sequencer;

  logic        mgt_clk = 1'b0;
  logic        reset_n;
  logic        force_reset;
  logic        powerdown_req;
  logic [3:0]  mgt_rxlock;
  logic [3:0]  mgt_syncok;
  logic [7:0]  mgt_codevalid;
  logic [3:0]  mgt_rxbufferr;
  logic [3:0]  mgt_tx_reset;
  logic [3:0]  mgt_rx_reset;
  logic [3:0]  mgt_enable_align;
  logic        mgt_enchansync;
  logic        mgt_powerdown;
  logic        link_up;
  logic [2:0]  seq_state;
  logic [7:0]  retry_count;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  always #5 mgt_clk = ~mgt_clk;

  xaui_link_sequencer #(
    .RESET_CYCLES(8),
    .LOCK_TIMEOUT(32),
    .ALIGN_TIMEOUT(32),
    .STABLE_CYCLES(4)
  ) dut (
    .mgt_clk(mgt_clk),
    .reset_n(reset_n),
    .force_reset(force_reset),
    .powerdown_req(powerdown_req),
    .mgt_rxlock(mgt_rxlock),
    .mgt_syncok(mgt_syncok),
    .mgt_codevalid(mgt_codevalid),
    .mgt_rxbufferr(mgt_rxbufferr),
    .mgt_tx_reset(mgt_tx_reset),
    .mgt_rx_reset(mgt_rx_reset),
    .mgt_enable_align(mgt_enable_align),
    .mgt_enchansync(mgt_enchansync),
    .mgt_powerdown(mgt_powerdown),
    .link_up(link_up),
    .seq_state(seq_state),
    .retry_count(retry_count),
    .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge mgt_clk);
    #1;
  endtask

  task automatic all_good();
    mgt_rxlock    = 4'hF;
    mgt_syncok    = 4'hF;
    mgt_codevalid = 8'hFF;
    mgt_rxbufferr = 4'h0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic bring_up();
    all_good();
    do_reset();
    step(13);
    chk("bring_up", {31'd0, link_up}, 32'd1);
  endtask

  initial begin
    reset_n       = 1'b0;
    force_reset   = 1'b0;
    powerdown_req = 1'b0;
    all_good();
    #1;
    chk("rst_tx", {28'd0, mgt_tx_reset}, 32'hF);
    chk("rst_rx", {28'd0, mgt_rx_reset}, 32'hF);
    chk("rst_align", {28'd0, mgt_enable_align}, 32'h0);
    chk("rst_chan", {31'd0, mgt_enchansync}, 32'd0);
    chk("rst_pd", {31'd0, mgt_powerdown}, 32'd0);
    chk("rst_link", {31'd0, link_up}, 32'd0);
    chk("rst_state", {29'd0, seq_state}, 32'd0);

    // clean bring-up
    step(2);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ra_state", {29'd0, seq_state}, 32'd0);
      chk("ra_tx", {28'd0, mgt_tx_reset}, 32'hF);
      step(1);
    end
    chk("wl_state", {29'd0, seq_state}, 32'd1);
    chk("wl_tx", {28'd0, mgt_tx_reset}, 32'h0);
    step(1);
    chk("al_state", {29'd0, seq_state}, 32'd2);
    chk("al_align", {28'd0, mgt_enable_align}, 32'hF);
    chk("al_chan", {31'd0, mgt_enchansync}, 32'd1);
    step(3);
    chk("al_3good", {31'd0, link_up}, 32'd0);
    step(1);
    chk("up_link", {31'd0, link_up}, 32'd1);
    chk("up_state", {29'd0, seq_state}, 32'd3);
    chk("up_align", {28'd0, mgt_enable_align}, 32'h0);
    chk("up_retry", {24'd0, retry_count}, 32'd0);
    chk("up_err", {16'd0, err_count}, 32'd0);

    // lock timeouts
    mgt_rxlock = 4'h0;
    do_reset();
    step(8);
    chk("to_wl", {29'd0, seq_state}, 32'd1);
    step(31);
    chk("to_pre", {29'd0, seq_state}, 32'd1);
    chk("to_pre_r", {24'd0, retry_count}, 32'd0);
    step(1);
    chk("to_1", {29'd0, seq_state}, 32'd0);
    chk("to_1_r", {24'd0, retry_count}, 32'd1);
    step(40);
    chk("to_2_r", {24'd0, retry_count}, 32'd2);
    mgt_rxlock = 4'hF;
    step(13);
    chk("to_relock", {31'd0, link_up}, 32'd1);
    chk("to_relock_r", {24'd0, retry_count}, 32'd2);

    // retry saturation
    mgt_rxlock = 4'h0;
    do_reset();
    step(254 * 40);
    chk("sat_254", {24'd0, retry_count}, 32'd254);
    step(40);
    chk("sat_255", {24'd0, retry_count}, 32'd255);
    step(45 * 40);
    chk("sat_hold", {24'd0, retry_count}, 32'd255);

    // rx buffer error recovery
    bring_up();
    mgt_rxbufferr = 4'b0100;
    step(1);
    mgt_rxbufferr = 4'h0;
    chk("rxr_state", {29'd0, seq_state}, 32'd4);
    chk("rxr_rx", {28'd0, mgt_rx_reset}, 32'hF);
    chk("rxr_tx", {28'd0, mgt_tx_reset}, 32'h0);
    chk("rxr_link", {31'd0, link_up}, 32'd0);
    chk("rxr_err", {16'd0, err_count}, 32'd1);
    step(7);
    chk("rxr_held", {29'd0, seq_state}, 32'd4);
    step(1);
    chk("rxr_wl", {29'd0, seq_state}, 32'd1);
    step(5);
    chk("rxr_up", {31'd0, link_up}, 32'd1);
    chk("rxr_err2", {16'd0, err_count}, 32'd1);

    // async reset mid-UP clears everything before the next edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_link", {31'd0, link_up}, 32'd0);
    chk("ar_tx", {28'd0, mgt_tx_reset}, 32'hF);
    chk("ar_rx", {28'd0, mgt_rx_reset}, 32'hF);
    chk("ar_state", {29'd0, seq_state}, 32'd0);
    chk("ar_err", {16'd0, err_count}, 32'd0);
    step(1);
    reset_n = 1'b1;

    // simultaneous sync and lock loss in UP
    bring_up();
    mgt_syncok = 4'b1101;
    mgt_rxlock = 4'b1110;
    step(1);
    all_good();
    chk("ll_state", {29'd0, seq_state}, 32'd0);
    chk("ll_link", {31'd0, link_up}, 32'd0);
    chk("ll_err", {16'd0, err_count}, 32'd1);
    step(9);
    chk("cv_align", {29'd0, seq_state}, 32'd2);
    for (int i = 0; i < 32; i++) begin
      chk("cv_noup", {29'd0, seq_state}, 32'd2);
      mgt_codevalid = (i % 3 == 2) ? 8'hFE : 8'hFF;
      step(1);
    end
    mgt_codevalid = 8'hFF;
    chk("cv_to", {29'd0, seq_state}, 32'd0);
    chk("cv_retry", {24'd0, retry_count}, 32'd1);

    // powerdown with force_reset mid-ALIGN
    all_good();
    do_reset();
    step(10);
    chk("pd_pre", {29'd0, seq_state}, 32'd2);
    powerdown_req = 1'b1;
    force_reset   = 1'b1;
    step(1);
    chk("pd_state", {29'd0, seq_state}, 32'd5);
    chk("pd_pd", {31'd0, mgt_powerdown}, 32'd1);
    chk("pd_tx", {28'd0, mgt_tx_reset}, 32'hF);
    step(3);
    chk("pd_hold", {29'd0, seq_state}, 32'd5);
    powerdown_req = 1'b0;
    force_reset   = 1'b0;
    step(1);
    chk("pd_exit", {29'd0, seq_state}, 32'd0);
    chk("pd_off", {31'd0, mgt_powerdown}, 32'd0);
    step(7);
    chk("pd_ra7", {29'd0, seq_state}, 32'd0);
    step(1);
    chk("pd_wl", {29'd0, seq_state}, 32'd1);
    chk("pd_retry", {24'd0, retry_count}, 32'd0);
    chk("pd_err", {16'd0, err_count}, 32'd0);

    // force_reset from UP counts once and holds RESET_ALL
    bring_up();
    force_reset = 1'b1;
    step(1);
    chk("fr_state", {29'd0, seq_state}, 32'd0);
    chk("fr_err", {16'd0, err_count}, 32'd1);
    step(20);
    chk("fr_hold", {29'd0, seq_state}, 32'd0);
    force_reset = 1'b0;
    step(7);
    chk("fr_ra7", {29'd0, seq_state}, 32'd0);
    step(1);
    chk("fr_wl", {29'd0, seq_state}, 32'd1);
    chk("fr_retry", {24'd0, retry_count}, 32'd0);
    chk("fr_err2", {16'd0, err_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
